// File: rtl/cdc_pkg.sv
// Types and constants shared by the CDC sampler and its downstream qualifiers.
package cdc_pkg;
  localparam int CDC_CNT_W = 8;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } cdc_qual_state_e;
endpackage

// File: rtl/cdc_stable_capture.sv
// Accepts a sampled CDC bus only after STABLE_CYCLES equal samples; each qualified
// change is published once through a one-entry valid/ready register (newest wins).
module cdc_stable_capture
  import cdc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sample_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CDC_CNT_W-1:0] overwrite_cnt
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
    $fatal(1, "cdc_stable_capture: STABLE_CYCLES must be within 1..255");
  end

  localparam logic [CDC_CNT_W-1:0] CNT_LAST = CDC_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CDC_CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0]     r_cand;
  logic [CDC_CNT_W-1:0] r_cnt;
  cdc_qual_state_e      r_state;

  logic w_change;
  logic w_settled;
  logic w_event;

  assign w_change  = (sample_in != r_cand);
  assign w_settled = (r_state == SETTLE) && (r_cnt == CNT_LAST);
  // A bounce that returns to the published value settles without an event.
  assign w_event   = !w_change && w_settled && (r_cand != data_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand        <= '0;
      r_cnt         <= '0;
      r_state       <= STABLE;
      data_out      <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      overwrite_cnt <= '0;
    end else begin
      if (w_change) begin
        r_cand  <= sample_in;
        r_cnt   <= '0;
        r_state <= SETTLE;
      end else if (w_settled) begin
        r_state <= STABLE;
        if (r_cand != data_out) data_out <= r_cand;
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt + CDC_CNT_W'(1);
      end

      if (w_event) begin
        out_data  <= r_cand;
        out_valid <= 1'b1;
        // Replacing an unaccepted value is a loss worth counting; a same-edge transfer is not.
        if (out_valid && !out_ready && overwrite_cnt != CNT_MAX)
          overwrite_cnt <= overwrite_cnt + CDC_CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
